// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - RV32I funct3 codes and data-memory FSM state type (package riscv_defs)
package riscv_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl_lane_align.sv
// rtl/dmem_ctrl_lane_align.sv - combinational byte-lane steering for stores and extension for loads
module dmem_lane_align
  import riscv_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic        st_err,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  logic [31:0] rshift;

  always_comb begin
    st_be   = 4'b0000;
    st_data = 32'h0;
    st_err  = 1'b0;
    case (funct3)
      F3_SB: begin
        st_be   = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        st_err  = addr_lo[0];
        st_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      F3_SW: begin
        st_err  = |addr_lo;
        st_be   = 4'b1111;
        st_data = wdata;
      end
      default: st_err = 1'b1;
    endcase
    // An erroring store must never touch the array.
    if (st_err) st_be = 4'b0000;
  end

  assign rshift = rword >> {addr_lo, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    ld_err  = 1'b0;
    case (funct3)
      F3_LB:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
      F3_LBU: ld_data = {24'h0, rshift[7:0]};
      F3_LH: begin
        ld_err  = addr_lo[0];
        ld_data = {{16{rshift[15]}}, rshift[15:0]};
      end
      F3_LHU: begin
        ld_err  = addr_lo[0];
        ld_data = {16'h0, rshift[15:0]};
      end
      F3_LW: begin
        ld_err  = |addr_lo;
        ld_data = rword;
      end
      default: ld_err = 1'b1;
    endcase
    if (ld_err) ld_data = 32'h0;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data memory with valid/ready handshake and wait states
// Optional out-of-range error and err_oor output under DMEM_BOUNDS_CHECK_EN.
module dmem_ctrl
  import riscv_defs::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_BOUNDS_CHECK_EN
  output logic        err_oor,
`endif
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  dmem_state_e      state;
  logic [3:0]       cnt;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic             st_err;
  logic [31:0]      ld_data;
  logic             ld_err;
  logic             oor;
  logic             err_all;
  logic             accept;

  assign idx     = req_addr[IDX_W+1:2];
  assign rword   = mem[idx];
  assign accept  = req_valid && req_ready;
  assign err_all = (req_we ? st_err : ld_err) | oor;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic oor_q;
  assign oor     = |req_addr[31:IDX_W+2];
  assign err_oor = rsp_valid && oor_q;
`else
  logic unused_upper;
  assign oor          = 1'b0;
  assign unused_upper = ^req_addr[31:IDX_W+2];
`endif

  dmem_lane_align u_align (
    .funct3  (req_funct3),
    .addr_lo (req_addr[1:0]),
    .wdata   (req_wdata),
    .rword   (rword),
    .st_be   (st_be),
    .st_data (st_data),
    .st_err  (st_err),
    .ld_data (ld_data),
    .ld_err  (ld_err)
  );

  // The array has no reset; a store commits at its acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err_all) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
      oor_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rdata_q <= (req_we || err_all) ? 32'h0 : ld_data;
            err_q   <= err_all;
`ifdef DMEM_BOUNDS_CHECK_EN
            oor_q   <= oor;
`endif
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl at LATENCY 0 and 3
module tb_dmem_ctrl;
  import riscv_defs::*;

  localparam int LAT1 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  logic        oor0, oor1;
  logic        req_ready, rsp_valid, rsp_err, err_oor;
  logic [31:0] rsp_rdata;

  exp_t        sb[$];
  logic [7:0]  mb [2][1024];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign req_ready = sel ? req_ready1 : req_ready0;
  assign rsp_valid = sel ? rsp_valid1 : rsp_valid0;
  assign rsp_err   = sel ? rsp_err1   : rsp_err0;
  assign rsp_rdata = sel ? rsp_rdata1 : rsp_rdata0;
  assign err_oor   = sel ? oor1       : oor0;

`ifndef DMEM_BOUNDS_CHECK_EN
  assign oor0 = 1'b0;
  assign oor1 = 1'b0;
`endif

  dmem_ctrl #(.MEM_WORDS(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & ~sel), .req_ready(req_ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rsp_rdata0),
`ifdef DMEM_BOUNDS_CHECK_EN
    .err_oor(oor0),
`endif
    .rsp_err(rsp_err0)
  );

  dmem_ctrl #(.MEM_WORDS(256), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid & sel), .req_ready(req_ready1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & sel), .rsp_rdata(rsp_rdata1),
`ifdef DMEM_BOUNDS_CHECK_EN
    .err_oor(oor1),
`endif
    .rsp_err(rsp_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference memory, independent of the word/lane structure in the RTL.
  function automatic exp_t model(input bit s, input bit we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t       e;
    logic [9:0] ba;
    logic [7:0] b0, b1, b2, b3;
    bit         mis;
    ba = a[9:0];
    e.rdata = 32'h0;
    e.oor   = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
    e.oor = (a >= 32'd1024);
`endif
    if (we) begin
      case (f3)
        3'b000:  mis = 1'b0;
        3'b001:  mis = a[0];
        3'b010:  mis = (a[1:0] != 2'b00);
        default: mis = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: mis = 1'b0;
        3'b001, 3'b101: mis = a[0];
        3'b010:         mis = (a[1:0] != 2'b00);
        default:        mis = 1'b1;
      endcase
    end
    e.err = mis | e.oor;
    if (e.err) return e;
    if (we) begin
      mb[s][ba] = wd[7:0];
      if (f3 != 3'b000) mb[s][ba + 10'd1] = wd[15:8];
      if (f3 == 3'b010) begin
        mb[s][ba + 10'd2] = wd[23:16];
        mb[s][ba + 10'd3] = wd[31:24];
      end
    end else begin
      b0 = mb[s][ba];
      b1 = mb[s][ba + 10'd1];
      b2 = mb[s][ba + 10'd2];
      b3 = mb[s][ba + 10'd3];
      case (f3)
        3'b000:  e.rdata = {{24{b0[7]}}, b0};
        3'b100:  e.rdata = {24'h0, b0};
        3'b001:  e.rdata = {{16{b1[7]}}, b1, b0};
        3'b101:  e.rdata = {16'h0, b1, b0};
        default: e.rdata = {b3, b2, b1, b0};
      endcase
    end
    return e;
  endfunction

  task automatic do_req(input string tag, input bit s, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    exp_t e;
    int   n;
    sb.push_back(model(s, we, f3, a, wd));
    sel = s; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    check({tag, ":latency"}, n, s ? LAT1 : 0);
    e = sb.pop_front();
    if (hold > 0) begin
      // A competing store is offered while the response is parked; it must be refused.
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
      req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
        check({tag, ":hold_rdata"}, rsp_rdata, e.rdata);
      end
      req_valid = 1'b0;
    end
    check({tag, ":rdata"}, rsp_rdata, e.rdata);
    check({tag, ":err"}, 32'(rsp_err), 32'(e.err));
`ifdef DMEM_BOUNDS_CHECK_EN
    check({tag, ":err_oor"}, 32'(err_oor), 32'(e.oor));
`endif
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ":retired"}, 32'(rsp_valid), 32'd0);
    check({tag, ":idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready0), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid0 | rsp_valid1), 32'd0);
    check("rst_rsp_rdata", rsp_rdata0, 32'h0);
    check("rst_rsp_err", 32'(rsp_err0), 32'd0);
    check("rst_err_oor", 32'(oor0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req("sw10",   0, 1, F3_SW,  32'h10, 32'h8000_00F1, 0);
    do_req("lw10",   0, 0, F3_LW,  32'h10, 32'h0, 0);
    do_req("sb13",   0, 1, F3_SB,  32'h13, 32'hFFFF_FFAB, 0);
    do_req("lb13",   0, 0, F3_LB,  32'h13, 32'h0, 0);
    do_req("lbu13",  0, 0, F3_LBU, 32'h13, 32'h0, 0);
    do_req("lw10b",  0, 0, F3_LW,  32'h10, 32'h0, 0);
    do_req("sw20",   0, 1, F3_SW,  32'h20, 32'h5566_7788, 0);
    do_req("sh22",   0, 1, F3_SH,  32'h22, 32'hABCD_1234, 0);
    do_req("lh22",   0, 0, F3_LH,  32'h22, 32'h0, 0);
    do_req("lhu20",  0, 0, F3_LHU, 32'h20, 32'h0, 0);
    do_req("lw11",   0, 0, F3_LW,  32'h11, 32'h0, 0);
    do_req("sh21",   0, 1, F3_SH,  32'h21, 32'hFFFF_FFFF, 0);
    do_req("ld011",  0, 0, 3'b011, 32'h20, 32'h0, 0);
    do_req("st011",  0, 1, 3'b011, 32'h20, 32'h0BAD_0BAD, 0);
    do_req("lw20",   0, 0, F3_LW,  32'h20, 32'h0, 0);
    do_req("sh30",   0, 1, F3_SH,  32'h30, 32'h0000_8001, 0);
    do_req("lh30",   0, 0, F3_LH,  32'h30, 32'h0, 0);
    do_req("lb31",   0, 0, F3_LB,  32'h31, 32'h0, 0);
    do_req("lw410",  0, 0, F3_LW,  32'h410, 32'h0, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    do_req("lw400",  0, 0, F3_LW,  32'h400, 32'h0, 0);
    do_req("sw410",  0, 1, F3_SW,  32'h410, 32'h1111_2222, 0);
    do_req("lw10c",  0, 0, F3_LW,  32'h10, 32'h0, 0);
`endif

    do_req("l3_sw40", 1, 1, F3_SW, 32'h40, 32'hCAFE_F00D, 0);
    do_req("l3_sw44", 1, 1, F3_SW, 32'h44, 32'h1122_3344, 0);
    do_req("l3_hold", 1, 0, F3_LW, 32'h44, 32'h0, 5);
    do_req("l3_lw40", 1, 0, F3_LW, 32'h40, 32'h0, 0);

    // Reset pulse while the slow instance is in WAIT.
    sel = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h40; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("rst_mid:req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid:in_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid:req_ready_now", 32'(req_ready1), 32'd1);
    check("rst_mid:rsp_valid_now", 32'(rsp_valid1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_mid:dropped", 32'(rsp_valid1), 32'd0);
    end

    do_req("post_rst_lw10", 0, 0, F3_LW, 32'h10, 32'h0, 0);
    do_req("post_rst_lw40", 1, 0, F3_LW, 32'h40, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory; the LSU talks to it.
- Adds RV32I byte/halfword/word access, sign/zero extension, byte-lane stores and misalignment detection.
- Adds a valid/ready request/response handshake with a programmable wait-state count, so the core can be exercised against slow memory.
- Sits between the core's MEM stage and an internal word-addressed SRAM array.

Parameters:
- MEM_WORDS, 256, number of 32-bit words; power of two, at least 4.
- LATENCY, 0, extra wait cycles between request acceptance and response; range 0..15.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 size/sign code (riscv_defs encoding)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; bits used are set by the access size
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned access or illegal funct3

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Memory array contents are not reset.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - A response is retired on a rising edge where rsp_valid && rsp_ready.
  - Requests are never accepted while a response is pending.
- FSM states:
  - IDLE: req_ready = 1. On acceptance, go to WAIT with counter = LATENCY-1 if LATENCY > 0; otherwise go to RESP.
  - WAIT: req_ready = 0, rsp_valid = 0. Decrement the counter; go to RESP when the counter is 0.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err stay stable until retired. On retire, go to IDLE.
- Latency: a request accepted at edge N has rsp_valid high in the cycle after edge N+LATENCY. Peak throughput is 1 access per LATENCY+2 cycles.
- Word index = req_addr[$clog2(MEM_WORDS)+1:2]. Upper address bits are ignored; the address wraps modulo MEM_WORDS*4.
- Access is performed at the acceptance edge:
  - Loads: read the word, extract by addr[1:0], extend, and register into the response register.
  - Stores: write only the selected byte lanes. The response returns rdata = 0.
- Loads by funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword from addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
- Stores by funct3:
  - 000 SB: lane addr[1:0] gets wdata[7:0].
  - 001 SH: lanes {addr[1],0..1} get wdata[15:0].
  - 010 SW: all lanes.
- Errors:
  - Conditions: halfword with addr[0]=1, word with addr[1:0]≠0, or any unlisted funct3 (loads 011/110/111, stores ≥011).
  - Response: rsp_err = 1, rsp_rdata = 0, and no memory write.
  - The error still goes through the normal latency and handshake.
- Back-to-back: a store then a load to the same address returns the new data, since the write completes before the next acceptance.
- Reset mid-operation returns the FSM to IDLE and drops any pending response. A store that was already accepted stays committed.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds an out-of-range error: req_addr ≥ MEM_WORDS*4 sets rsp_err = 1, rsp_rdata = 0, and suppresses the write.
  - Adds output err_oor (1 bit), high with rsp_valid when the error cause is out-of-range.
- Undefined: no range check and no err_oor port; addresses wrap.

Decomposition:
- riscv_defs package: funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW) and the dmem_state_e enum (IDLE, WAIT, RESP).
- Sub-module dmem_lane_align, combinational:
  - Store path: funct3 + addr[1:0] + wdata give byte enables, shifted write data and the misalign flag.
  - Load path: word + funct3 + addr[1:0] give extended rdata.
- The top level holds the FSM, counter, response register and array.

Test Plan:
- LATENCY=0: SW 0x8000_00F1 @0x10, then LW @0x10 → rsp_valid one cycle after acceptance, rdata 0x8000_00F1, err 0.
- SB 0xAB @0x13, then LB @0x13 → 0xFFFF_FFAB; LBU @0x13 → 0x0000_00AB; LW @0x10 → 0xAB00_00F1.
- SH 0x1234 @0x22, then LH @0x22 → 0x0000_1234; LHU @0x20 returns the lower half unchanged.
- Misaligned LW @0x11 and SH @0x21 → err=1, rdata=0; a following LW @0x20 shows memory unchanged.
- LATENCY=3 with rsp_ready held low for 5 cycles:
  - rsp_valid rises 4 cycles after acceptance and holds stable.
  - req_ready stays 0 until retire.
  - A req_valid asserted meanwhile is not accepted.
- rst_n pulsed low during WAIT → rsp_valid and req_ready return to reset values immediately. With DMEM_BOUNDS_CHECK_EN, LW @0x400 (MEM_WORDS=256) → err=1, err_oor=1.
